seg7_time_display: RTL and testbench

Multiplexed six-digit seven-segment driver for the hh:mm:ss clock. It consumes the 24-bit packed BCD time word produced by the time counter, snapshots it once per scan frame to avoid tearing, and scans one digit at a time onto the board's common-anode display. It supports per-digit blinking for set mode, hour-tens leading-zero suppression, and an error glyph for invalid BCD nibbles.

---
 rtl/seg7_pkg.sv | 31 +++
 rtl/seg7_time_display_if.sv | 15 +
 rtl/bcd_to_seg.sv | 26 ++
 rtl/seg7_time_display.sv | 96 +++++++++
 tb/tb_seg7_time_display.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and types for the six-digit seven-segment scanner
package seg7_pkg;

  localparam int NUM_DIGITS = 6;

  typedef logic [6:0] seg_t;
  typedef logic [2:0] digit_idx_t;

  // Active-low {g,f,e,d,c,b,a}
  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_DASH  = 7'b0111111;
  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam digit_idx_t SEP_IDX_MINUTES = 3'd2;
  localparam digit_idx_t SEP_IDX_HOURS   = 3'd4;
  localparam digit_idx_t LAST_DIGIT      = 3'(NUM_DIGITS - 1);

  function automatic logic [NUM_DIGITS-1:0] digit_enable_n(input digit_idx_t idx);
    return ~(NUM_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/seg7_time_display_if.sv
// rtl/seg7_time_display_if.sv - time word in, multiplexed display drive out
interface seg7_time_display_if;
  import seg7_pkg::*;

  logic [23:0]           data;
  logic [NUM_DIGITS-1:0] blink;
  logic [NUM_DIGITS-1:0] an;
  seg_t                  seg;
  logic                  dp;
  logic                  frame_start;

  modport master (output data, blink, input an, seg, dp, frame_start);
  modport slave  (input data, blink, output an, seg, dp, frame_start);

endinterface

// File: rtl/bcd_to_seg.sv
// rtl/bcd_to_seg.sv - BCD nibble to active-low segment pattern, dash for 10..15
module bcd_to_seg
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output seg_t       o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_nib)
      4'd0: o_seg = SEG_0;
      4'd1: o_seg = SEG_1;
      4'd2: o_seg = SEG_2;
      4'd3: o_seg = SEG_3;
      4'd4: o_seg = SEG_4;
      4'd5: o_seg = SEG_5;
      4'd6: o_seg = SEG_6;
      4'd7: o_seg = SEG_7;
      4'd8: o_seg = SEG_8;
      4'd9: o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_time_display.sv
// rtl/seg7_time_display.sv - frame-snapshotted hh:mm:ss scanner with blink and leading-zero blanking
module seg7_time_display
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input logic CLK,
  input logic reset,
  seg7_time_display_if.slave bus
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_FRAMES - 1);

  logic [PW-1:0]         r_pre;
  digit_idx_t            r_idx;
  logic [23:0]           r_snap;
  logic [BW-1:0]         r_bcnt;
  logic                  r_phase;
  logic [NUM_DIGITS-1:0] r_an;
  seg_t                  r_seg;
  logic                  r_dp;
  logic                  r_frame_start;

  logic       w_pre_wrap;
  logic       w_frame_wrap;
  logic [3:0] w_nib;
  seg_t       w_glyph;
  logic       w_blank;

  assign w_pre_wrap   = (r_pre == PRE_LAST);
  assign w_frame_wrap = w_pre_wrap && (r_idx == LAST_DIGIT);

  always_comb begin
    w_nib = r_snap[3:0];
    case (r_idx)
      3'd1: w_nib = r_snap[7:4];
      3'd2: w_nib = r_snap[11:8];
      3'd3: w_nib = r_snap[15:12];
      3'd4: w_nib = r_snap[19:16];
      3'd5: w_nib = r_snap[23:20];
      default: w_nib = r_snap[3:0];
    endcase
  end

  bcd_to_seg u_bcd_to_seg (
    .i_nib (w_nib),
    .o_seg (w_glyph)
  );

  // Blink uses the live enable so set-mode edits show up without waiting a frame
  assign w_blank = (bus.blink[r_idx] && r_phase) ||
                   ((r_idx == LAST_DIGIT) && (w_nib == 4'd0));

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_pre         <= '0;
      r_idx         <= '0;
      r_snap        <= '0;
      r_bcnt        <= '0;
      r_phase       <= 1'b0;
      r_an          <= '1;
      r_seg         <= SEG_BLANK;
      r_dp          <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_pre <= w_pre_wrap ? '0 : r_pre + 1'b1;
      if (w_pre_wrap) begin
        r_idx <= (r_idx == LAST_DIGIT) ? '0 : r_idx + 3'd1;
      end
      // Snapshot only at the frame boundary so a frame never mixes two time values
      if (w_frame_wrap) begin
        r_snap <= bus.data;
        if (r_bcnt == BCNT_LAST) begin
          r_bcnt  <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_bcnt <= r_bcnt + 1'b1;
        end
      end
      r_an          <= digit_enable_n(r_idx);
      r_seg         <= w_blank ? SEG_BLANK : w_glyph;
      r_dp          <= ~((r_idx == SEP_IDX_MINUTES) || (r_idx == SEP_IDX_HOURS));
      r_frame_start <= (r_idx == '0) && (r_pre == '0);
    end
  end

  assign bus.an          = r_an;
  assign bus.seg         = r_seg;
  assign bus.dp          = r_dp;
  assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_seg7_time_display.sv
// tb/tb_seg7_time_display.sv - directed bench for seg7_time_display, SCAN_DIV=4, BLINK_FRAMES=2
module tb_seg7_time_display;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_tests = 0;
  int n_fail = 0;

  seg7_time_display_if bus ();

  seg7_time_display #(
    .SCAN_DIV     (4),
    .BLINK_FRAMES (2)
  ) dut (
    .CLK   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input int n);
    case (n)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic logic [5:0] an_exp(input int d);
    case (d)
      0: return 6'b111110;
      1: return 6'b111101;
      2: return 6'b111011;
      3: return 6'b110111;
      4: return 6'b101111;
      default: return 6'b011111;
    endcase
  endfunction

  // Reset for one edge with the given inputs; the next posedge is the first running edge.
  task automatic release_reset(input logic [23:0] d, input logic [5:0] b);
    @(negedge clk);
    reset = 1'b1;
    bus.data = d;
    bus.blink = b;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1;
    bus.data = 24'h123456;
    bus.blink = 6'b0;
    @(negedge clk);
    n_tests++; if (bus.an !== 6'b111111) begin n_fail++; $display("FAIL reset_an got %b exp %b", bus.an, 6'b111111); end
    n_tests++; if (bus.seg !== 7'b1111111) begin n_fail++; $display("FAIL reset_seg got %b exp %b", bus.seg, 7'b1111111); end
    n_tests++; if (bus.dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp got %b exp 1", bus.dp); end
    n_tests++; if (bus.frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_fs got %b exp 0", bus.frame_start); end
    reset = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.frame_start !== 1'b1) begin n_fail++; $display("FAIL first_fs got %b exp 1", bus.frame_start); end
    n_tests++; if (bus.an !== 6'b111110) begin n_fail++; $display("FAIL first_an got %b exp %b", bus.an, 6'b111110); end
    n_tests++; if (bus.seg !== 7'b1000000) begin n_fail++; $display("FAIL first_seg got %b exp %b", bus.seg, 7'b1000000); end
  endtask

  task automatic test_basic_scan;
    logic [6:0] e [6];
    logic [6:0] es;
    int d, f;
    e = '{glyph(6), glyph(5), glyph(4), glyph(3), glyph(2), glyph(1)};
    release_reset(24'h123456, 6'b0);
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      d = (c % 24) / 4;
      f = c / 24;
      es = (f == 0) ? ((d == 5) ? 7'b1111111 : 7'b1000000) : e[d];
      n_tests++; if (bus.an !== an_exp(d)) begin n_fail++; $display("FAIL basic_an c=%0d got %b exp %b", c, bus.an, an_exp(d)); end
      n_tests++; if (bus.seg !== es) begin n_fail++; $display("FAIL basic_seg c=%0d got %b exp %b", c, bus.seg, es); end
      n_tests++; if (bus.dp !== ((d == 2 || d == 4) ? 1'b0 : 1'b1)) begin n_fail++; $display("FAIL basic_dp c=%0d got %b", c, bus.dp); end
      n_tests++; if (bus.frame_start !== ((c % 24) == 0)) begin n_fail++; $display("FAIL basic_fs c=%0d got %b", c, bus.frame_start); end
    end
  endtask

  task automatic test_leading_zero;
    logic [6:0] e [6];
    int d;
    e = '{glyph(0), glyph(3), glyph(5), glyph(4), glyph(9), 7'b1111111};
    release_reset(24'h094530, 6'b0);
    repeat (24) @(negedge clk);
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      d = c / 4;
      n_tests++; if (bus.an !== an_exp(d)) begin n_fail++; $display("FAIL lz_an c=%0d got %b exp %b", c, bus.an, an_exp(d)); end
      n_tests++; if (bus.seg !== e[d]) begin n_fail++; $display("FAIL lz_seg c=%0d got %b exp %b", c, bus.seg, e[d]); end
      n_tests++; if (bus.dp !== ((d == 2 || d == 4) ? 1'b0 : 1'b1)) begin n_fail++; $display("FAIL lz_dp c=%0d got %b", c, bus.dp); end
    end
  endtask

  task automatic test_tear_free;
    logic [6:0] e1 [6];
    logic [6:0] e2 [6];
    logic [6:0] es;
    int d;
    e1 = '{glyph(9), glyph(5), glyph(9), glyph(5), glyph(3), glyph(2)};
    e2 = '{glyph(0), glyph(0), glyph(0), glyph(0), glyph(0), 7'b1111111};
    release_reset(24'h235959, 6'b0);
    repeat (24) @(negedge clk);
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      d = (c % 24) / 4;
      es = (c < 24) ? e1[d] : e2[d];
      n_tests++; if (bus.seg !== es) begin n_fail++; $display("FAIL tear_seg c=%0d got %b exp %b", c, bus.seg, es); end
      if (c == 10) bus.data = 24'h000000;
    end
  endtask

  task automatic test_invalid_bcd;
    logic [6:0] e [6];
    int d;
    e = '{glyph(0), glyph(0), 7'b0111111, 7'b0111111, glyph(0), 7'b1111111};
    release_reset(24'h00FA00, 6'b0);
    repeat (24) @(negedge clk);
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      d = c / 4;
      n_tests++; if (bus.seg !== e[d]) begin n_fail++; $display("FAIL invalid_seg c=%0d got %b exp %b", c, bus.seg, e[d]); end
    end
  endtask

  task automatic test_blink;
    logic [6:0] e [6];
    logic [6:0] es;
    int d, f;
    e = '{glyph(6), glyph(5), glyph(4), glyph(3), glyph(2), glyph(1)};
    release_reset(24'h123456, 6'b000011);
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      d = (c % 24) / 4;
      f = c / 24;
      es = (f == 0) ? ((d == 5) ? 7'b1111111 : 7'b1000000) : e[d];
      if (d < 2 && (f == 2 || f == 3)) es = 7'b1111111;
      n_tests++; if (bus.seg !== es) begin n_fail++; $display("FAIL blink_seg f=%0d d=%0d got %b exp %b", f, d, bus.seg, es); end
      n_tests++; if (bus.an !== an_exp(d)) begin n_fail++; $display("FAIL blink_an f=%0d d=%0d got %b exp %b", f, d, bus.an, an_exp(d)); end
    end
    bus.blink = 6'b0;
  endtask

  task automatic test_reset_mid_frame;
    release_reset(24'h123456, 6'b0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.an !== 6'b111111) begin n_fail++; $display("FAIL mid_rst_an got %b exp %b", bus.an, 6'b111111); end
    n_tests++; if (bus.seg !== 7'b1111111) begin n_fail++; $display("FAIL mid_rst_seg got %b exp %b", bus.seg, 7'b1111111); end
    n_tests++; if (bus.dp !== 1'b1) begin n_fail++; $display("FAIL mid_rst_dp got %b exp 1", bus.dp); end
    n_tests++; if (bus.frame_start !== 1'b0) begin n_fail++; $display("FAIL mid_rst_fs got %b exp 0", bus.frame_start); end
    reset = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.frame_start !== 1'b1) begin n_fail++; $display("FAIL mid_rel_fs got %b exp 1", bus.frame_start); end
    n_tests++; if (bus.an !== 6'b111110) begin n_fail++; $display("FAIL mid_rel_an got %b exp %b", bus.an, 6'b111110); end
    n_tests++; if (bus.seg !== 7'b1000000) begin n_fail++; $display("FAIL mid_rel_seg got %b exp %b", bus.seg, 7'b1000000); end
    repeat (23) @(negedge clk);
    @(negedge clk);
    n_tests++; if (bus.frame_start !== 1'b1) begin n_fail++; $display("FAIL mid_next_fs got %b exp 1", bus.frame_start); end
    n_tests++; if (bus.seg !== glyph(6)) begin n_fail++; $display("FAIL mid_next_seg got %b exp %b", bus.seg, glyph(6)); end
  endtask

  initial begin
    bus.data = 24'h0;
    bus.blink = 6'b0;
    test_reset();
    test_basic_scan();
    test_leading_zero();
    test_tear_free();
    test_invalid_bcd();
    test_blink();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
